fle_fabric_param: RTL and testbench

FLE_FABRIC_PARAM -- requirements
Module: fle_fabric_param

---
 rtl/fle_pkg.sv | 32 +++
 rtl/fle_fabric_param_if.sv | 19 +
 rtl/fle_cfg_chain.sv | 31 +++
 rtl/fle_fabric_param.sv | 99 +++++++++
 tb/tb_fle_fabric_param.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fle_pkg.sv
// rtl/fle_pkg.sv - mode encodings and config field offsets for the fracturable logic element
package fle_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE     = 2'b00,
    MODE_FRAC       = 2'b01,
    MODE_ARITH      = 2'b10,
    MODE_SINGLE_ALT = 2'b11
  } fle_mode_e;

  // Chain layout, LSB first: truth table, mode, dsel, osel
  function automatic int tt_bits(input int k);
    return 1 << k;
  endfunction

  function automatic int cfg_bits(input int k);
    return (1 << k) + 6;
  endfunction

  function automatic int mode_lsb(input int k);
    return 1 << k;
  endfunction

  function automatic int dsel_lsb(input int k);
    return (1 << k) + 2;
  endfunction

  function automatic int osel_lsb(input int k);
    return (1 << k) + 4;
  endfunction

endpackage

// File: rtl/fle_fabric_param_if.sv
// rtl/fle_fabric_param_if.sv - fabric-side data bus of the logic element
interface fle_fabric_param_if #(parameter int LUT_K = 4);
  logic [LUT_K-1:0] fabric_in;
  logic             fabric_cin;
  logic             fabric_cout;
  logic             fabric_reg_in;
  logic [1:0]       fabric_out;
  logic             fabric_reg_out;

  modport master (
    output fabric_in, fabric_cin, fabric_reg_in,
    input  fabric_cout, fabric_out, fabric_reg_out
  );

  modport slave (
    input  fabric_in, fabric_cin, fabric_reg_in,
    output fabric_cout, fabric_out, fabric_reg_out
  );
endinterface

// File: rtl/fle_cfg_chain.sv
// rtl/fle_cfg_chain.sv - serial configuration shift register with saturating load counter
module fle_cfg_chain
  import fle_pkg::*;
#(
  parameter int CFG_BITS = cfg_bits(4)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_en,
  input  logic                head,
  output logic [CFG_BITS-1:0] cfg,
  output logic                done
);

  localparam int CW = $clog2(CFG_BITS + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg   <= '0;
      count <= '0;
    end else if (shift_en) begin
      cfg <= {cfg[CFG_BITS-2:0], head};
      if (count != CW'(CFG_BITS)) count <= count + 1'b1;
    end
  end

  assign done = (count == CW'(CFG_BITS));

endmodule

// File: rtl/fle_fabric_param.sv
// rtl/fle_fabric_param.sv - fracturable K-LUT logic element with carry and two output registers
// Optional scan path on ff0/ff1 enabled by defining FLE_SCAN_EN.
module fle_fabric_param
  import fle_pkg::*;
#(
  parameter int LUT_K = 4
) (
  input  logic fabric_clk,
  input  logic fabric_reset,
  input  logic ccff_shift_en,
  input  logic ccff_head,
  output logic ccff_tail,
  output logic cfg_done,
`ifdef FLE_SCAN_EN
  input  logic test_enable,
  input  logic fabric_sc_in,
  output logic fabric_sc_out,
`endif
  fle_fabric_param_if.slave bus
);

  localparam int CFG_BITS = cfg_bits(LUT_K);
  localparam int TT       = tt_bits(LUT_K);
  localparam int HALF     = TT / 2;

  logic [CFG_BITS-1:0] cfg;
  logic [TT-1:0]       tt;
  logic [HALF-1:0]     tt_lo;
  logic [HALF-1:0]     tt_hi;
  fle_mode_e           mode;
  logic [1:0]          dsel;
  logic [1:0]          osel;
  logic                full, lo, hi;
  logic [1:0]          lut_out;
  logic                cout;
  logic                ff0, ff1;
  logic                capture;

  fle_cfg_chain #(.CFG_BITS(CFG_BITS)) u_cfg (
    .clk      (fabric_clk),
    .rst      (fabric_reset),
    .shift_en (ccff_shift_en),
    .head     (ccff_head),
    .cfg      (cfg),
    .done     (cfg_done)
  );

  assign tt    = cfg[TT-1:0];
  assign tt_lo = tt[HALF-1:0];
  assign tt_hi = tt[TT-1:HALF];
  assign mode  = fle_mode_e'(cfg[mode_lsb(LUT_K) +: 2]);
  assign dsel  = cfg[dsel_lsb(LUT_K) +: 2];
  assign osel  = cfg[osel_lsb(LUT_K) +: 2];

  // Both halves share the low K-1 inputs; the top input only selects within the full LUT
  assign full = tt[bus.fabric_in];
  assign lo   = tt_lo[bus.fabric_in[LUT_K-2:0]];
  assign hi   = tt_hi[bus.fabric_in[LUT_K-2:0]];

  always_comb begin
    lut_out = {full, lo};
    cout    = 1'b0;
    case (mode)
      MODE_FRAC:  lut_out = {hi, lo};
      MODE_ARITH: begin
        lut_out = {lo, lo ^ bus.fabric_cin};
        cout    = lo ? bus.fabric_cin : hi;
      end
      default: ;
    endcase
  end

  // Registers stay frozen while the chain is partially loaded or being rewritten
  assign capture = cfg_done & ~ccff_shift_en;

  always_ff @(posedge fabric_clk or posedge fabric_reset) begin
    if (fabric_reset) begin
      ff0 <= 1'b0;
      ff1 <= 1'b0;
`ifdef FLE_SCAN_EN
    end else if (test_enable) begin
      ff0 <= fabric_sc_in;
      ff1 <= ff0;
`endif
    end else if (capture) begin
      ff0 <= dsel[0] ? lut_out[0] : bus.fabric_reg_in;
      ff1 <= dsel[1] ? lut_out[1] : ff0;
    end
  end

  assign bus.fabric_out     = {osel[1] ? ff1 : lut_out[1], osel[0] ? ff0 : lut_out[0]};
  assign bus.fabric_reg_out = ff1;
  assign bus.fabric_cout    = cout;
  assign ccff_tail          = cfg[CFG_BITS-1];
`ifdef FLE_SCAN_EN
  assign fabric_sc_out      = ff1;
`endif

endmodule

// File: tb/tb_fle_fabric_param.sv
// tb/tb_fle_fabric_param.sv - randomized self-checking bench for fle_fabric_param (LUT_K=4)
module tb_fle_fabric_param;

  localparam int K  = 4;
  localparam int CB = 22;

  logic clk = 1'b0;
  logic rst;
  logic shift_en, head, tail, done;
`ifdef FLE_SCAN_EN
  logic test_enable, sc_in, sc_out;
`endif

  fle_fabric_param_if #(.LUT_K(K)) bus ();

  fle_fabric_param #(.LUT_K(K)) dut (
    .fabric_clk    (clk),
    .fabric_reset  (rst),
    .ccff_shift_en (shift_en),
    .ccff_head     (head),
    .ccff_tail     (tail),
    .cfg_done      (done),
`ifdef FLE_SCAN_EN
    .test_enable   (test_enable),
    .fabric_sc_in  (sc_in),
    .fabric_sc_out (sc_out),
`endif
    .bus           (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: config word as loaded, shift count, register contents
  logic [CB-1:0] m_cfg;
  int            m_cnt;
  logic          m_ff0, m_ff1;

  // Returns {cout, lut1, lut0} from the field meanings
  function automatic logic [2:0] m_comb(input logic [CB-1:0] c, input logic [K-1:0] in, input logic cin);
    int tt, mode, li;
    logic full, lo, hi;
    tt   = int'(c[15:0]);
    mode = int'(c[17:16]);
    li   = int'(in) % 8;
    full = 1'((tt >> int'(in)) & 1);
    lo   = 1'((tt >> li) & 1);
    hi   = 1'((tt >> (li + 8)) & 1);
    if (mode == 2)      return {(lo ? cin : hi), lo, lo ^ cin};
    else if (mode == 1) return {1'b0, hi, lo};
    else                return {1'b0, full, lo};
  endfunction

  function automatic logic [1:0] m_out(input logic [2:0] cb);
    return {m_cfg[21] ? m_ff1 : cb[1], m_cfg[20] ? m_ff0 : cb[0]};
  endfunction

  function automatic logic [CB-1:0] word(input logic [15:0] tt, input logic [1:0] mode,
                                         input logic [1:0] dsel, input logic [1:0] osel);
    return {osel, dsel, mode, tt};
  endfunction

  task automatic tick();
    logic [2:0] cb;
    logic       n0, n1;
    cb = m_comb(m_cfg, bus.fabric_in, bus.fabric_cin);
`ifdef FLE_SCAN_EN
    if (test_enable) begin
      m_ff1 = m_ff0;
      m_ff0 = sc_in;
    end else
`endif
    if (shift_en) begin
      m_cfg = {m_cfg[CB-2:0], head};
      if (m_cnt < CB) m_cnt++;
    end else if (m_cnt == CB) begin
      n0 = m_cfg[18] ? cb[0] : bus.fabric_reg_in;
      n1 = m_cfg[19] ? cb[1] : m_ff0;
      m_ff0 = n0;
      m_ff1 = n1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    m_cfg = '0;
    m_cnt = 0;
    m_ff0 = 1'b0;
    m_ff1 = 1'b0;
  endtask

  task automatic load(input logic [CB-1:0] w);
    shift_en = 1'b1;
    for (int i = CB - 1; i >= 0; i--) begin
      head = w[i];
      tick();
    end
    shift_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.fabric_in  = 4'($urandom);
    bus.fabric_cin = 1'($urandom);
    do_reset();
    #1;
    n_cmp++;
    if ({bus.fabric_out, bus.fabric_cout, bus.fabric_reg_out, done, tail} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b want 000000",
               {bus.fabric_out, bus.fabric_cout, bus.fabric_reg_out, done, tail});
    end
  endtask

  task automatic test_cfg_count();
    logic hist[$];
    logic exp_tail;
    do_reset();
    shift_en = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      head = 1'($urandom);
      hist.push_back(head);
      tick();
      exp_tail = (n >= CB) ? hist[n - CB] : 1'b0;
      n_cmp++;
      if ({done, tail} !== {(n >= CB), exp_tail}) begin
        n_fail++;
        $display("FAIL cfg_count shift %0d: done/tail got %b want %b", n, {done, tail}, {(n >= CB), exp_tail});
      end
    end
    shift_en = 1'b0;
  endtask

  task automatic test_midload_reset();
    do_reset();
    shift_en = 1'b1;
    for (int n = 0; n < 10; n++) begin head = 1'b1; tick(); end
    do_reset();
    for (int n = 1; n <= CB; n++) begin
      head = 1'($urandom);
      tick();
      if (n >= CB - 1) begin
        n_cmp++;
        if (done !== (n == CB)) begin
          n_fail++;
          $display("FAIL midload_reset shift %0d: done got %b want %b", n, done, (n == CB));
        end
      end
    end
    shift_en = 1'b0;
  endtask

  task automatic test_xor_table();
    logic [2:0] cb;
    do_reset();
    load(word(16'h6996, 2'b00, 2'b00, 2'b00));
    for (int v = 0; v < 16; v++) begin
      bus.fabric_in = 4'(v);
      #1;
      cb = m_comb(m_cfg, bus.fabric_in, bus.fabric_cin);
      n_cmp++;
      if ({bus.fabric_out, bus.fabric_cout} !== {^(4'(v)), cb[0], 1'b0}) begin
        n_fail++;
        $display("FAIL xor_table in=%h: out/cout got %b want %b", v,
                 {bus.fabric_out, bus.fabric_cout}, {^(4'(v)), cb[0], 1'b0});
      end
    end
  endtask

  task automatic test_arith();
    logic [15:0] tt;
    logic [2:0]  cb;
    logic [3:0]  iv;
    for (int i = 0; i < 8; i++) begin
      iv = 4'(i);
      tt[i]     = iv[0] ^ iv[1];
      tt[i + 8] = iv[0] & iv[1];
    end
    do_reset();
    load(word(tt, 2'b10, 2'b00, 2'b00));
    bus.fabric_in = 4'b0011; bus.fabric_cin = 1'b1; #1;
    n_cmp++;
    if ({bus.fabric_out[0], bus.fabric_cout} !== 2'b11) begin
      n_fail++;
      $display("FAIL arith_11: out0/cout got %b want 11", {bus.fabric_out[0], bus.fabric_cout});
    end
    bus.fabric_in = 4'b0001; bus.fabric_cin = 1'b1; #1;
    n_cmp++;
    if ({bus.fabric_out[0], bus.fabric_cout} !== 2'b01) begin
      n_fail++;
      $display("FAIL arith_10: out0/cout got %b want 01", {bus.fabric_out[0], bus.fabric_cout});
    end
    for (int v = 0; v < 32; v++) begin
      bus.fabric_in = 4'(v); bus.fabric_cin = 1'(v >> 4); #1;
      cb = m_comb(m_cfg, bus.fabric_in, bus.fabric_cin);
      n_cmp++;
      if ({bus.fabric_out, bus.fabric_cout} !== {cb[1:0], cb[2]}) begin
        n_fail++;
        $display("FAIL arith_sweep %0d: got %b want %b", v, {bus.fabric_out, bus.fabric_cout}, {cb[1:0], cb[2]});
      end
    end
  endtask

  task automatic test_pipeline();
    do_reset();
    bus.fabric_reg_in = 1'b0;
    load(word(16'($urandom), 2'b00, 2'b00, 2'b11));
    bus.fabric_reg_in = 1'b1;
    tick();
    bus.fabric_reg_in = 1'b0;
    n_cmp++;
    if (bus.fabric_out !== 2'b01) begin
      n_fail++;
      $display("FAIL pipeline_stage1: out got %b want 01", bus.fabric_out);
    end
    tick();
    n_cmp++;
    if ({bus.fabric_out, bus.fabric_reg_out} !== 3'b101) begin
      n_fail++;
      $display("FAIL pipeline_stage2: out/reg_out got %b want 101", {bus.fabric_out, bus.fabric_reg_out});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    load(word(16'h0000, 2'b00, 2'b00, 2'b01));
    bus.fabric_reg_in = 1'b1;
    tick();
    bus.fabric_reg_in = 1'b0;
    n_cmp++;
    if (bus.fabric_out[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL async_preload: out0 got %b want 1", bus.fabric_out[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.fabric_out, done, bus.fabric_reg_out} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset: out/done/reg_out got %b want 0000", {bus.fabric_out, done, bus.fabric_reg_out});
    end
    rst = 1'b0;
    m_cfg = '0; m_cnt = 0; m_ff0 = 1'b0; m_ff1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [2:0] cb;
    logic [5:0] got, exp;
    for (int r = 0; r < 5; r++) begin
      do_reset();
      load(CB'($urandom));
      for (int c = 0; c < 40; c++) begin
        bus.fabric_in     = 4'($urandom);
        bus.fabric_cin    = 1'($urandom);
        bus.fabric_reg_in = 1'($urandom);
        shift_en          = ($urandom_range(0, 7) == 0);
        head              = 1'($urandom);
        #1;
        cb  = m_comb(m_cfg, bus.fabric_in, bus.fabric_cin);
        exp = {m_out(cb), cb[2], m_ff1, (m_cnt == CB), m_cfg[CB-1]};
        got = {bus.fabric_out, bus.fabric_cout, bus.fabric_reg_out, done, tail};
        n_cmp++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL random cfg%0d cyc%0d: out,cout,reg,done,tail got %b want %b", r, c, got, exp);
        end
        tick();
      end
      shift_en = 1'b0;
    end
  endtask

`ifdef FLE_SCAN_EN
  task automatic test_scan();
    do_reset();
    test_enable = 1'b1;
    sc_in = 1'b1; tick();
    sc_in = 1'b0; tick();
    n_cmp++;
    if (sc_out !== 1'b1) begin
      n_fail++;
      $display("FAIL scan_two_edges: sc_out got %b want 1", sc_out);
    end
    tick();
    n_cmp++;
    if (sc_out !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_three_edges: sc_out got %b want 0", sc_out);
    end
    test_enable = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b0;
    shift_en = 1'b0;
    head = 1'b0;
    bus.fabric_in = '0;
    bus.fabric_cin = 1'b0;
    bus.fabric_reg_in = 1'b0;
`ifdef FLE_SCAN_EN
    test_enable = 1'b0;
    sc_in = 1'b0;
`endif
    @(posedge clk);
    #1;
    test_reset();
    test_cfg_count();
    test_midload_reset();
    test_xor_table();
    test_arith();
    test_pipeline();
    test_async_reset();
    test_random();
`ifdef FLE_SCAN_EN
    test_scan();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
